fir_sample_buffer: RTL and testbench
====================================

FIR_SAMPLE_BUFFER -- requirements
Module: fir_sample_buffer

Interface
REQ-001 The block SHALL have parameter DW, 18, sample width in bits.
REQ-002 The block SHALL have parameter LANES, 8, samples delivered per read.
REQ-003 The block SHALL have parameter ROWS, 2048, rows per bank (depth = LANES*ROWS = 16384 samples).
REQ-004 The block SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port din  in  18  new signed input sample.
REQ-007 The block SHALL have port din_valid  in  1  din is valid this cycle.
REQ-008 The block SHALL have port din_ready  out  1  block accepts din this cycle.
REQ-009 The block SHALL have port addr_data  in  11  read row from the FIR MAC stage.
REQ-010 The block SHALL have port datain  out  144  8 past samples, newest lane in [143:126].
REQ-011 The block SHALL have port datain_ready  out  1  one-cycle pulse that starts the FIR.
REQ-012 The block SHALL have port fir_done  in  1  dataout_ready pulse from the FIR stage.

Function
REQ-013 The block SHALL transfer din when din_valid and din_ready are both high at a rising edge.
REQ-014 The block SHALL write the transferred sample at 14-bit write index wp, then set wp to wp+1 mod 16384.
REQ-015 The block SHALL store sample index i in bank i mod 8 at row i div 8.
REQ-016 The block SHALL define newest as wp-1 mod 16384.
REQ-017 The block SHALL drive datain lane j (j=0..7, lane 0 = [143:126]) with sample index (newest - 8*addr_data - j) mod 16384.
REQ-018 The block SHALL register datain one cycle after addr_data is sampled (read latency 1), using a rotated bank mux and a per-bank row borrow.
REQ-019 The block SHALL implement FSM CLEAR, IDLE, NOTIFY, BUSY.
REQ-020 In CLEAR the block SHALL zero one row per cycle over rows 0..2047, then go to IDLE; din_ready is low.
REQ-021 In IDLE din_ready SHALL be high; on a transfer the FSM goes to NOTIFY.
REQ-022 In NOTIFY datain_ready SHALL be high for exactly one cycle (the cycle after the transfer edge), then the FSM goes to BUSY.
REQ-023 In BUSY din_ready SHALL be low; on fir_done the FSM returns to IDLE, with din_ready high the next cycle.
REQ-024 The block SHALL ignore fir_done outside BUSY.
REQ-025 The block SHALL keep reads legal in every state; there are no writes in BUSY, so read/write collisions cannot occur.
REQ-026 The block SHALL wrap wp from 16383 to 0 with no flag; the oldest sample is overwritten.

Reset
REQ-027 While reset is low: wp=0, datain=0, datain_ready=0, din_ready=0, FSM=CLEAR when SAMPLE_BUFFER_CLEAR_EN is defined, else IDLE.
REQ-028 Reset asserted mid-FIR or mid-CLEAR SHALL abort immediately; a CLEAR sweep restarts from row 0 after release.

Configuration
REQ-029 With SAMPLE_BUFFER_CLEAR_EN defined, the block SHALL run the 2048-cycle CLEAR sweep after reset, so unwritten taps read 0.
REQ-030 With SAMPLE_BUFFER_CLEAR_EN undefined, the block SHALL omit CLEAR and the row counter, enter IDLE out of reset, and leave memory contents undefined until written.

Structure
REQ-031 The shared package fir_pkg SHALL hold DW, LANES, ROWS, the derived index width 14, and the FSM state encoding.
REQ-032 The block SHALL instantiate LANES copies of sub-module fir_sample_bank (ROWS x DW, one write port, one synchronous read port, read latency 1).

Verification
REQ-033 Reset release with CLEAR_EN -> din_ready low for exactly 2048 cycles, then high; any read -> datain all 0.
REQ-034 Write 1,2,...,9 (fir_done after each) then addr_data=0 -> datain lanes = 9,8,7,6,5,4,3,2; addr_data=1 -> lane0=1, lanes 1..7 = 0.
REQ-035 Transfer at edge T -> datain_ready high only in cycle T+1; din_valid held high -> din_ready low until the cycle after fir_done.
REQ-036 Write 16385 samples of value i mod 2^17 -> wp=1; addr_data=2047 -> lane7 = sample index 1 (value 1), lane0 = sample index 8.
REQ-037 Reset pulsed during BUSY -> datain_ready and datain immediately 0; fir_done then arriving -> ignored, FSM still in CLEAR.
REQ-038 fir_done pulse while in IDLE -> no state change, din_ready stays high.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the FIR sample buffer.
package fir_pkg;

    localparam int DW    = 18;
    localparam int LANES = 8;
    localparam int ROWS  = 2048;
    localparam int IDX_W = 14;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        NOTIFY = 2'd2,
        BUSY   = 2'd3
    } state_t;

endpackage

// File: rtl/fir_sample_bank.sv
// One bank of the sample buffer: ROWS x DW, one write port, one synchronous read port.
module fir_sample_bank #(
    parameter  int DW   = 18,
    parameter  int ROWS = 2048,
    localparam int RW   = $clog2(ROWS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [RW-1:0]        wr_row,
    input  logic signed [DW-1:0] wr_data,
    input  logic [RW-1:0]        rd_row,
    output logic signed [DW-1:0] rd_data
);

    logic signed [DW-1:0] mem [ROWS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    // The read register clears on reset so the assembled tap vector reads zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_row];
        end
    end

endmodule

// File: rtl/fir_sample_buffer.sv
// Circular sample buffer feeding LANES past samples per read to a FIR MAC stage.
// Optional power-up clear sweep is enabled by defining SAMPLE_BUFFER_CLEAR_EN.
module fir_sample_buffer #(
    parameter int DW    = fir_pkg::DW,
    parameter int LANES = fir_pkg::LANES,
    parameter int ROWS  = fir_pkg::ROWS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [DW-1:0]    din,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [$clog2(ROWS)-1:0] addr_data,
    output logic [LANES*DW-1:0]     datain,
    output logic                    datain_ready,
    input  logic                    fir_done
);

    import fir_pkg::*;

    localparam int LW = $clog2(LANES);
    localparam int RW = $clog2(ROWS);
    localparam int IW = LW + RW;

    state_t               state;
    logic [IW-1:0]        wp;
    logic                 take;
`ifdef SAMPLE_BUFFER_CLEAR_EN
    logic [RW-1:0]        clr_row;
`endif

    logic [LANES-1:0]     wr_en;
    logic [RW-1:0]        wr_row;
    logic signed [DW-1:0] wr_data;

    logic [IW-1:0]        newest;
    logic [IW-1:0]        base;
    logic [RW-1:0]        base_row;
    logic [LW-1:0]        base_lane;
    logic [LW-1:0]        sel_lane;
    logic [RW-1:0]        rd_row [LANES];
    logic signed [DW-1:0] bank_q [LANES];

    assign take = din_valid && din_ready;

    always_comb begin
        wr_en   = '0;
        wr_row  = wp[IW-1:LW];
        wr_data = din;
        wr_en[wp[LW-1:0]] = take;
`ifdef SAMPLE_BUFFER_CLEAR_EN
        if (state == CLEAR) begin
            wr_en   = '1;
            wr_row  = clr_row;
            wr_data = '0;
        end
`endif
    end

    // Lane 0 is the sample at base; lower lanes step back through the banks,
    // and any bank above base_lane holds its lane one row earlier.
    assign newest    = wp - 1'b1;
    assign base      = newest - {addr_data, {LW{1'b0}}};
    assign base_row  = base[IW-1:LW];
    assign base_lane = base[LW-1:0];

    for (genvar k = 0; k < LANES; k++) begin : g_bank
        assign rd_row[k] = (LW'(k) <= base_lane) ? base_row : base_row - 1'b1;

        fir_sample_bank #(
            .DW   (DW),
            .ROWS (ROWS)
        ) u_bank (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (wr_en[k]),
            .wr_row  (wr_row),
            .wr_data (wr_data),
            .rd_row  (rd_row[k]),
            .rd_data (bank_q[k])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_lane <= '0;
        end else begin
            sel_lane <= base_lane;
        end
    end

    always_comb begin
        datain = '0;
        for (int j = 0; j < LANES; j++) begin
            datain[(LANES-1-j)*DW +: DW] = bank_q[sel_lane - LW'(j)];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp           <= '0;
            din_ready    <= 1'b0;
            datain_ready <= 1'b0;
`ifdef SAMPLE_BUFFER_CLEAR_EN
            state        <= CLEAR;
            clr_row      <= '0;
`else
            state        <= IDLE;
`endif
        end else begin
            datain_ready <= 1'b0;
            case (state)
`ifdef SAMPLE_BUFFER_CLEAR_EN
                CLEAR: begin
                    clr_row <= clr_row + 1'b1;
                    if (clr_row == RW'(ROWS - 1)) begin
                        state     <= IDLE;
                        din_ready <= 1'b1;
                    end
                end
`endif
                IDLE: begin
                    if (take) begin
                        wp           <= wp + 1'b1;
                        state        <= NOTIFY;
                        din_ready    <= 1'b0;
                        datain_ready <= 1'b1;
                    end else begin
                        din_ready    <= 1'b1;
                    end
                end
                NOTIFY: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (fir_done) begin
                        state     <= IDLE;
                        din_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    din_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_buffer.sv
// Self-checking bench for fir_sample_buffer: vector table, handshake sequences, random model compare.
`timescale 1ns/1ps
module tb_fir_sample_buffer;

    localparam int DW    = 18;
    localparam int LANES = 8;
    localparam int ROWS  = 2048;
    localparam int DEPTH = LANES * ROWS;
    localparam int SKIP  = -999999;
`ifdef SAMPLE_BUFFER_CLEAR_EN
    localparam bit CLR_KNOWN = 1'b1;
    localparam int Z = 0;
`else
    localparam bit CLR_KNOWN = 1'b0;
    localparam int Z = SKIP;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic                 din_valid = 1'b0;
    logic                 din_ready;
    logic [10:0]          addr_data = '0;
    logic [LANES*DW-1:0]  datain;
    logic                 datain_ready;
    logic                 fir_done = 1'b0;

    int vectors;
    int miscompares;

    int mem_m [DEPTH];
    bit known [DEPTH];
    int wp_m;

    typedef struct {
        int addr;
        int exp [8];
    } rd_vec_t;
    rd_vec_t tbl [3];

    always #5 clock = ~clock;

    fir_sample_buffer dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .addr_data    (addr_data),
        .datain       (datain),
        .datain_ready (datain_ready),
        .fir_done     (fir_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane(input int j);
        logic signed [DW-1:0] s;
        s = datain[(LANES-1-j)*DW +: DW];
        return int'(s);
    endfunction

    task automatic model_reset();
        wp_m = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 0;
            known[i] = CLR_KNOWN;
        end
    endtask

    task automatic model_write(input int v);
        mem_m[wp_m] = v;
        known[wp_m] = 1'b1;
        wp_m = (wp_m + 1) % DEPTH;
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        @(negedge clock);
        while (!din_ready && n < bound) begin
            @(negedge clock);
            n++;
        end
        chk("din_ready_wait", int'(din_ready), 1);
    endtask

    // Counts rising edges with din_ready low after release; optional fir_done pulse meanwhile.
    task automatic settle(input bit pulse);
        int low  = 0;
        int seen = 0;
        while (!din_ready && low < 3000) begin
            fir_done = pulse && (low >= 3) && (low < 6);
            low++;
            @(negedge clock);
            if (datain_ready) seen++;
        end
        fir_done = 1'b0;
`ifdef SAMPLE_BUFFER_CLEAR_EN
        chk("clear_low_cycles", low, ROWS);
`else
        chk("noclear_low_cycles", int'(low <= 1), 1);
`endif
        chk("settle_no_notify", seen, 0);
        chk("settle_din_ready", int'(din_ready), 1);
    endtask

    task automatic push(input int v, input bit done);
        wait_ready(20);
        din = 18'(v);
        din_valid = 1'b1;
        @(posedge clock);
        model_write(v);
        #1;
        chk("push_notify", int'(datain_ready), 1);
        chk("push_ready_low", int'(din_ready), 0);
        @(negedge clock);
        din_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("push_notify_single", int'(datain_ready), 0);
        if (done) begin
            @(negedge clock);
            fir_done = 1'b1;
            @(posedge clock);
            #1;
            fir_done = 1'b0;
            chk("push_ready_after_done", int'(din_ready), 1);
        end
    endtask

    task automatic read_check(input int a, input string tag);
        @(negedge clock);
        addr_data = 11'(a);
        @(posedge clock);
        #1;
        for (int j = 0; j < LANES; j++) begin
            int idx;
            idx = ((wp_m - 1 - 8 * a - j) % DEPTH + DEPTH) % DEPTH;
            if (known[idx]) chk($sformatf("%s_a%0d_l%0d", tag, a, j), lane(j), mem_m[idx]);
        end
    endtask

    function automatic int rand_sample();
        int v;
        v = int'($urandom_range(1, 262143));
        if (v >= 131072) v = v - 262144;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        vectors     = 0;
        miscompares = 0;
        model_reset();

        tbl[0] = '{addr: 0,    exp: '{9, 8, 7, 6, 5, 4, 3, 2}};
        tbl[1] = '{addr: 1,    exp: '{1, Z, Z, Z, Z, Z, Z, Z}};
        tbl[2] = '{addr: 2047, exp: '{Z, Z, Z, Z, Z, Z, Z, Z}};

        // Reset values and release
        repeat (3) @(negedge clock);
        chk("rst_din_ready", int'(din_ready), 0);
        chk("rst_datain_ready", int'(datain_ready), 0);
        chk("rst_datain_zero", int'(datain == '0), 1);
        reset = 1'b1;
        settle(1'b0);

        // fir_done in IDLE is ignored
        @(negedge clock);
        fir_done = 1'b1;
        @(posedge clock);
        #1;
        fir_done = 1'b0;
        chk("idle_done_ready", int'(din_ready), 1);
        chk("idle_done_notify", int'(datain_ready), 0);
        @(posedge clock);
        #1;
        chk("idle_done_ready2", int'(din_ready), 1);

        // Samples 1..9 and the lane table
        for (int i = 1; i <= 9; i++) push(i, 1'b1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            addr_data = 11'(tbl[t].addr);
            @(posedge clock);
            #1;
            for (int j = 0; j < LANES; j++) begin
                if (tbl[t].exp[j] != SKIP)
                    chk($sformatf("tbl%0d_l%0d", t, j), lane(j), tbl[t].exp[j]);
            end
        end

        // din_valid held high across a full FIR cycle
        @(negedge clock);
        din = 18'd100;
        din_valid = 1'b1;
        @(posedge clock);
        model_write(100);
        #1;
        chk("hold_notify", int'(datain_ready), 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            chk("hold_busy_ready", int'(din_ready), 0);
            chk("hold_busy_notify", int'(datain_ready), 0);
        end
        @(negedge clock);
        fir_done = 1'b1;
        din = 18'd101;
        @(posedge clock);
        #1;
        fir_done = 1'b0;
        chk("hold_ready_after_done", int'(din_ready), 1);
        chk("hold_no_notify", int'(datain_ready), 0);
        @(posedge clock);
        model_write(101);
        #1;
        chk("hold_second_notify", int'(datain_ready), 1);
        @(negedge clock);
        din_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("hold_second_single", int'(datain_ready), 0);
        @(negedge clock);
        fir_done = 1'b1;
        @(posedge clock);
        #1;
        fir_done = 1'b0;
        chk("hold_final_ready", int'(din_ready), 1);
        read_check(0, "hold");

        // Random samples against the model
        for (int n = 0; n < 40; n++) push(rand_sample(), 1'b1);
        for (int n = 0; n < 20; n++) read_check(int'($urandom_range(0, 7)), "rnd");
        for (int n = 0; n < 4; n++) read_check(int'($urandom_range(0, 2047)), "rndf");

        // Reset during BUSY aborts immediately
        @(negedge clock);
        addr_data = '0;
        v = rand_sample();
        push(v, 1'b0);
        chk("busy_lane0", lane(0), v);
        #2;
        reset = 1'b0;
        #1;
        chk("busy_rst_datain_zero", int'(datain == '0), 1);
        chk("busy_rst_notify", int'(datain_ready), 0);
        chk("busy_rst_ready", int'(din_ready), 0);
        model_reset();
        @(negedge clock);
        fir_done = 1'b1;
        @(negedge clock);
        fir_done = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        settle(1'b1);

        // 16385 samples wrap the write pointer to 1
        fir_done = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wait_ready(8);
            din = 18'(i % 131072);
            din_valid = 1'b1;
            @(posedge clock);
            model_write(i % 131072);
        end
        @(negedge clock);
        din_valid = 1'b0;
        repeat (3) @(negedge clock);
        fir_done = 1'b0;
        chk("wrap_idle_ready", int'(din_ready), 1);
        read_check(2047, "wrap");
        chk("wrap_lane7", lane(7), 1);
        chk("wrap_lane0", lane(0), 8);
        read_check(0, "wrap");
        chk("wrap_overwritten", lane(0), 16384);
        chk("wrap_prev", lane(1), 16383);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
